x3_serial_add_ctrl: RTL and testbench

- Sequencer that adds two multi-digit excess-3 (XS-3) operands using one shared single-digit XS-3 adder, one digit per clock, least-significant digit first.
- Latches the operands on start, drives the external digit adder, ripples the carry through a register and assembles the result.
- Pulses done when the result is ready and flags invalid XS-3 operand digits.
- Sits between a requesting unit and the single-digit XS-3 adder datapath.

---
 rtl/x3_serial_add_ctrl.sv | 150 +++++++++++++++
 tb/tb_x3_serial_add_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/x3_serial_add_ctrl.sv
// x3_serial_add_ctrl
// Multi-digit excess-3 adder sequencer. Uses one external single-digit XS-3
// adder once per clock, least-significant digit first, and rippling the
// decimal carry through a register. A one-cycle done pulse marks the result.
module x3_serial_add_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a_in,
   input  logic [4*DIGITS-1:0]   b_in,
   input  logic                  cin,
   output logic [3:0]            dig_a,
   output logic [3:0]            dig_b,
   output logic                  dig_cin,
   input  logic [3:0]            dig_sum,
   input  logic                  dig_cout,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int W     = 4 * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
   localparam logic [3:0] XS3_ZERO = 4'b0011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [W-1:0]     op_a;
   logic [W-1:0]     op_b;
   logic [IDX_W-1:0] idx;
   logic             carry;
   logic [3:0]       cur_a;
   logic [3:0]       cur_b;
   logic             accept;

   // A digit is legal XS-3 only in the range 0011..1100.
   function automatic logic has_bad_digit(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if ((v[i*4 +: 4] < 4'b0011) || (v[i*4 +: 4] > 4'b1100)) begin
            bad = 1'b1;
         end
      end
      return bad;
   endfunction

   assign accept = (state == IDLE) && start;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Select the operand digits addressed by the current index.
   always_comb begin
      cur_a = XS3_ZERO;
      cur_b = XS3_ZERO;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_a = op_a[i*4 +: 4];
            cur_b = op_b[i*4 +: 4];
         end
      end
   end

   // Next-state and outputs; digit adder sees XS-3 zero outside RUN.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      dig_a     = XS3_ZERO;
      dig_b     = XS3_ZERO;
      dig_cin   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy    = 1'b1;
            dig_a   = cur_a;
            dig_b   = cur_b;
            dig_cin = carry;
            if (idx == LAST_IDX) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture on an accepted start; pure data, no reset needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_a <= a_in;
         op_b <= b_in;
      end
   end

   // Index, carry ripple, result assembly and error flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx   <= '0;
         carry <= 1'b0;
         sum   <= {DIGITS{XS3_ZERO}};
         cout  <= 1'b0;
         err   <= 1'b0;
      end else if (accept) begin
         idx   <= '0;
         carry <= cin;
         err   <= has_bad_digit(a_in) | has_bad_digit(b_in);
      end else if (state == RUN) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
               sum[i*4 +: 4] <= dig_sum;
            end
         end
         carry <= dig_cout;
         idx   <= idx + 1'b1;
         if (idx == LAST_IDX) begin
            cout <= dig_cout;
         end
      end
   end

endmodule

// File: tb/tb_x3_serial_add_ctrl.sv
// Testbench for x3_serial_add_ctrl: directed cases plus random operations,
// with a single-digit XS-3 adder model on the dig_* ports and an integer
// decimal reference for the multi-digit result.
module tb_x3_serial_add_ctrl;

   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  a_in;
   logic [W-1:0]  b_in;
   logic          cin;
   logic [3:0]    dig_a;
   logic [3:0]    dig_b;
   logic          dig_cin;
   logic [3:0]    dig_sum;
   logic          dig_cout;
   logic [W-1:0]  sum;
   logic          cout;
   logic          busy;
   logic          done;
   logic          err;

   int n_chk = 0;
   int n_err = 0;
   logic cin_seen [DIGITS];

   x3_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a_in     (a_in),
      .b_in     (b_in),
      .cin      (cin),
      .dig_a    (dig_a),
      .dig_b    (dig_b),
      .dig_cin  (dig_cin),
      .dig_sum  (dig_sum),
      .dig_cout (dig_cout),
      .sum      (sum),
      .cout     (cout),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Single-digit XS-3 adder: decimal digit add with carry, re-encoded.
   always_comb begin
      int ds;
      ds = int'(dig_a) + int'(dig_b) + int'(dig_cin) - 6;
      dig_cout = 1'b0;
      if (ds >= 10) begin
         dig_cout = 1'b1;
         ds = ds - 10;
      end
      dig_sum = 4'(ds + 3);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Decimal reference: operands as integers, add, re-encode in XS-3.
   function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, output logic [W-1:0] s,
                                   output logic co, output logic e);
      int va, vb, tot, lim;
      logic [3:0] da, db;
      va = 0; vb = 0; lim = 1; e = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         da = a[i*4 +: 4];
         db = b[i*4 +: 4];
         if (da < 4'd3 || da > 4'd12 || db < 4'd3 || db > 4'd12) e = 1'b1;
         va = va * 10 + int'(da) - 3;
         vb = vb * 10 + int'(db) - 3;
         lim = lim * 10;
      end
      tot = va + vb + int'(ci);
      co = (tot >= lim);
      if (co) tot = tot - lim;
      s = '0;
      for (int i = 0; i < DIGITS; i++) begin
         s[i*4 +: 4] = 4'(tot % 10 + 3);
         tot = tot / 10;
      end
   endfunction

   function automatic logic [W-1:0] rand_operand(input bit bad);
      logic [W-1:0] v;
      int k;
      logic [3:0] badv;
      for (int i = 0; i < DIGITS; i++) v[i*4 +: 4] = 4'($urandom_range(3, 12));
      if (bad) begin
         k = $urandom_range(0, DIGITS - 1);
         case ($urandom_range(0, 5))
            0: badv = 4'd0;
            1: badv = 4'd1;
            2: badv = 4'd2;
            3: badv = 4'd13;
            4: badv = 4'd14;
            default: badv = 4'd15;
         endcase
         v[k*4 +: 4] = badv;
      end
      return v;
   endfunction

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      a_in = a; b_in = b; cin = ci; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Waits (bounded) for done after the start edge; n = edges to done.
   task automatic wait_done(output int n, output bit busy_ok);
      n = 0;
      busy_ok = 1'b1;
      cin_seen[0] = dig_cin;
      while (!done && n < 20) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         n++;
         if (n < DIGITS) cin_seen[n] = dig_cin;
      end
      if (!busy) busy_ok = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic ci);
      logic [W-1:0] es;
      logic eco, ee;
      ref_add(a, b, ci, es, eco, ee);
      chk({tag, "_done"}, 32'(done), 32'(1));
      chk({tag, "_err"}, 32'(err), 32'(ee));
      if (!ee) begin
         chk({tag, "_sum"}, 32'(sum), 32'(es));
         chk({tag, "_cout"}, 32'(cout), 32'(eco));
      end
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ci);
      int n;
      bit bok;
      start_op(a, b, ci);
      wait_done(n, bok);
      chk({tag, "_lat"}, 32'(n), 32'(DIGITS));
      chk({tag, "_busy"}, 32'(bok), 32'(1));
      check_result(tag, a, b, ci);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 32'(done), 32'(0));
      chk({tag, "_errhold"}, 32'(err), 32'(err));
   endtask

   initial begin
      int n;
      bit bok;
      bit done_seen;
      logic [W-1:0] ra, rb;
      logic rc;

      rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_sum", 32'(sum), 32'h3333);
      chk("rst_cout", 32'(cout), 32'(0));
      chk("rst_err", 32'(err), 32'(0));
      chk("rst_diga", 32'(dig_a), 32'h3);
      chk("rst_digb", 32'(dig_b), 32'h3);
      chk("rst_digcin", 32'(dig_cin), 32'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1234 + 5678
      run_op("t1", 16'h4567, 16'h89AB, 1'b0);
      chk("t1_sum_lit", 32'(sum), 32'h9C45);

      // 0000 + 0000 + cin
      run_op("t3", 16'h3333, 16'h3333, 1'b1);
      chk("t3_sum_lit", 32'(sum), 32'h3334);

      // Invalid digit, then a clean add clears err
      run_op("t4a", 16'h0567, 16'h3333, 1'b0);
      chk("t4a_err_lit", 32'(err), 32'(1));
      run_op("t4b", 16'h3334, 16'h3334, 1'b0);
      chk("t4b_sum_lit", 32'(sum), 32'h3335);
      chk("t4b_err_lit", 32'(err), 32'(0));

      // start held high, operands changed mid-RUN
      a_in = 16'h4567; b_in = 16'h89AB; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      a_in = 16'hCCCC; b_in = 16'h3334; cin = 1'b1;
      wait_done(n, bok);
      chk("t5a_lat", 32'(n), 32'(DIGITS));
      chk("t5a_busy", 32'(bok), 32'(1));
      check_result("t5a", 16'h4567, 16'h89AB, 1'b0);
      @(posedge clk); #1;
      chk("t5_idle_busy", 32'(busy), 32'(0));
      chk("t5_idle_done", 32'(done), 32'(0));
      @(posedge clk); #1;
      chk("t5b_busy0", 32'(busy), 32'(1));
      start = 1'b0;
      wait_done(n, bok);
      chk("t5b_lat", 32'(n), 32'(DIGITS));
      check_result("t5b", 16'hCCCC, 16'h3334, 1'b1);
      @(posedge clk); #1;

      // 9999 + 0001: carry ripples through every digit
      run_op("t2", 16'hCCCC, 16'h3334, 1'b0);
      chk("t2_sum_lit", 32'(sum), 32'h3333);
      chk("t2_cout_lit", 32'(cout), 32'(1));
      chk("t2_cin0", 32'(cin_seen[0]), 32'(0));
      for (int i = 1; i < DIGITS; i++) chk("t2_cin", 32'(cin_seen[i]), 32'(1));

      // Leave a non-reset result behind (9999+0002 -> 0001, carry out)
      run_op("t6pre", 16'hCCCC, 16'h3335, 1'b0);

      // Reset during the second RUN cycle
      start_op(16'h4567, 16'h89AB, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("t6_busy", 32'(busy), 32'(0));
      chk("t6_done", 32'(done), 32'(0));
      chk("t6_sum", 32'(sum), 32'h3333);
      chk("t6_cout", 32'(cout), 32'(0));
      done_seen = 1'b0;
      repeat (DIGITS + 3) begin
         @(posedge clk); #1;
         done_seen = done_seen | done;
      end
      chk("t6_nodone", 32'(done_seen), 32'(0));
      run_op("t6post", 16'h4567, 16'h89AB, 1'b0);

      // Random operations, some with illegal digits
      for (int t = 0; t < 40; t++) begin
         ra = rand_operand($urandom_range(0, 9) == 0);
         rb = rand_operand($urandom_range(0, 9) == 0);
         rc = 1'($urandom_range(0, 1));
         run_op("rnd", ra, rb, rc);
         chk("rnd_idle_diga", 32'(dig_a), 32'h3);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
